// File: rtl/sap2_computer.sv
// 8-bit SAP-style computer: multicycle CPU, 16-word RAM and output register on one clock.
// Each instruction takes a 7-step microcycle, preceded by a single idle edge after reset.

module sap2_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] latched_data
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    latched_data <= '0;
    else if (load) latched_data <= d;
  end
endmodule

module sap2_program_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] counter_out
);
  // Natural wrap from all-ones back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     counter_out <= '0;
    else if (load)  counter_out <= d;
    else if (inc)   counter_out <= counter_out + 1'b1;
  end
endmodule

module sap2_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

  // Read is combinational so the fetch step sees the addressed word in the same cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

  task automatic dump();
    for (int i = 0; i < RAM_DEPTH; i++) $display("ram[%0h] = %02h", i, mem[i]);
  endtask
endmodule

module sap2_cpu #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [DATA_WIDTH-1:0] out_value
);
  typedef enum logic [3:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} step_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_LDB = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                         OP_STA = 4'h5, OP_LDI = 4'h6, OP_JMP = 4'h7, OP_JC  = 4'h8,
                         OP_JZ  = 4'h9, OP_OUT = 4'hE, OP_HLT = 4'hF;
  localparam logic [1:0] A_FROM_RAM = 2'd0, A_FROM_ALU = 2'd1, A_FROM_IMM = 2'd2;

  step_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0] mar_reg;
  logic [DATA_WIDTH-1:0] ir_reg, b_reg, out_reg;
  logic                  flag_c, flag_z, halt;

  logic                  mar_load, ir_load, pc_inc, pc_load, a_load, b_load;
  logic                  flags_load, alu_sub, out_load, halt_set;
  logic [1:0]            a_src;
  logic [DATA_WIDTH-1:0] a_value, a_d;
  logic [ADDR_WIDTH-1:0] pc_value;
  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   alu_full;
  logic                  alu_carry, alu_zero;

  assign opcode  = ir_reg[7:4];
  assign operand = ir_reg[ADDR_WIDTH-1:0];

  sap2_register #(.WIDTH(DATA_WIDTH)) u_register_A (
    .clk(clk), .reset(reset), .load(a_load), .d(a_d), .latched_data(a_value)
  );

  sap2_program_counter #(.WIDTH(ADDR_WIDTH)) u_program_counter (
    .clk(clk), .reset(reset), .inc(pc_inc), .load(pc_load), .d(operand), .counter_out(pc_value)
  );

  // C on subtract means "no borrow", i.e. A >= B.
  assign alu_full  = alu_sub ? ({1'b0, a_value} - {1'b0, b_reg}) : ({1'b0, a_value} + {1'b0, b_reg});
  assign alu_carry = alu_sub ? ~alu_full[DATA_WIDTH] : alu_full[DATA_WIDTH];
  assign alu_zero  = (alu_full[DATA_WIDTH-1:0] == '0);

  always_comb begin
    case (a_src)
      A_FROM_ALU: a_d = alu_full[DATA_WIDTH-1:0];
      A_FROM_IMM: a_d = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand};
      default:    a_d = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!halt) begin
      case (state_reg)
        S_IDLE: state_next = S_T0;
        S_T0:   state_next = S_T1;
        S_T1:   state_next = S_T2;
        S_T2:   state_next = S_T3;
        S_T3:   state_next = S_T4;
        S_T4:   state_next = S_T5;
        S_T5:   state_next = S_T6;
        default: state_next = S_T0;
      endcase
    end
  end

  always_comb begin
    mar_load   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    a_load     = 1'b0;
    a_src      = A_FROM_RAM;
    b_load     = 1'b0;
    flags_load = 1'b0;
    alu_sub    = 1'b0;
    ram_we     = 1'b0;
    out_load   = 1'b0;
    halt_set   = 1'b0;
    ram_addr   = operand;
    if (!halt) begin
      case (state_reg)
        S_T0: mar_load = 1'b1;
        S_T1: begin
          ram_addr = mar_reg;
          ir_load  = 1'b1;
          pc_inc   = 1'b1;
        end
        S_T3: begin
          case (opcode)
            OP_LDA: a_load = 1'b1;
            OP_LDB: b_load = 1'b1;
            OP_ADD: begin a_load = 1'b1; a_src = A_FROM_ALU; flags_load = 1'b1; end
            OP_SUB: begin a_load = 1'b1; a_src = A_FROM_ALU; flags_load = 1'b1; alu_sub = 1'b1; end
            OP_STA: ram_we = 1'b1;
            OP_LDI: begin a_load = 1'b1; a_src = A_FROM_IMM; end
            OP_JMP: pc_load = 1'b1;
            OP_JC:  pc_load = flag_c;
            OP_JZ:  pc_load = flag_z;
            OP_OUT: out_load = 1'b1;
            OP_HLT: halt_set = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mar_reg <= '0;
      ir_reg  <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      halt    <= 1'b0;
    end else begin
      if (mar_load)   mar_reg <= pc_value;
      if (ir_load)    ir_reg  <= ram_rdata;
      if (b_load)     b_reg   <= ram_rdata;
      if (out_load)   out_reg <= a_value;
      if (flags_load) begin
        flag_c <= alu_carry;
        flag_z <= alu_zero;
      end
      if (halt_set)   halt <= 1'b1;
    end
  end

  assign ram_wdata = a_value;
  assign out_value = out_reg;
endmodule

module sap2_computer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] register_OUT
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  sap2_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );

  sap2_cpu #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_cpu (
    .clk(clk), .reset(reset), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .out_value(register_OUT)
  );
endmodule

// File: tb/tb_sap2_computer.sv
// Bench for sap2_computer: directed programs plus random programs, checked against an
// instruction-level interpreter that executes one whole instruction per model step.

module tb_sap2_computer;
  logic       clk;
  logic       reset;
  logic [7:0] register_OUT;

  int total = 0;
  int bad   = 0;

  sap2_computer dut (.clk(clk), .reset(reset), .register_OUT(register_OUT));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pgm   [16];
  int         m_mem [16];
  int         m_a, m_b, m_pc, m_c, m_z, m_out, m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pgm();
    for (int i = 0; i < 16; i++) pgm[i] = 8'h00;
  endtask

  // Hold reset, load RAM and the model, then release so the next rising edge is the idle edge.
  task automatic start();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      dut.u_ram.mem[i] = pgm[i];
      m_mem[i] = pgm[i];
    end
    m_a = 0; m_b = 0; m_pc = 0; m_c = 0; m_z = 0; m_out = 0; m_halt = 0;
    @(negedge clk);
    reset = 1'b1;
    edges(1);
  endtask

  // One full instruction at ISA level.
  task automatic model_step();
    int ins, op, opr, r;
    if (m_halt != 0) return;
    ins  = m_mem[m_pc];
    op   = ins / 16;
    opr  = ins % 16;
    m_pc = (m_pc + 1) % 16;
    case (op)
      1:  m_a = m_mem[opr];
      2:  m_b = m_mem[opr];
      3:  begin r = m_a + m_b; m_c = (r > 255) ? 1 : 0; m_a = r % 256; m_z = (m_a == 0) ? 1 : 0; end
      4:  begin m_c = (m_a >= m_b) ? 1 : 0; m_a = (m_a - m_b + 256) % 256; m_z = (m_a == 0) ? 1 : 0; end
      5:  m_mem[opr] = m_a;
      6:  m_a = opr;
      7:  m_pc = opr;
      8:  if (m_c != 0) m_pc = opr;
      9:  if (m_z != 0) m_pc = opr;
      14: m_out = m_a;
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  task automatic run_compare(input string tag, input int n, input bit full);
    for (int k = 0; k < n; k++) begin
      edges(7);
      model_step();
      check({tag, "_pc"}, 32'(dut.u_cpu.u_program_counter.counter_out), m_pc);
      check({tag, "_a"},  32'(dut.u_cpu.u_register_A.latched_data), m_a);
      if (full) begin
        check({tag, "_b"},    32'(dut.u_cpu.b_reg), m_b);
        check({tag, "_c"},    32'(dut.u_cpu.flag_c), m_c);
        check({tag, "_z"},    32'(dut.u_cpu.flag_z), m_z);
        check({tag, "_out"},  32'(register_OUT), m_out);
        check({tag, "_halt"}, 32'(dut.u_cpu.halt), m_halt);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_pgm();
    edges(3);
    check("rst_pc",   32'(dut.u_cpu.u_program_counter.counter_out), 0);
    check("rst_a",    32'(dut.u_cpu.u_register_A.latched_data), 0);
    check("rst_out",  32'(register_OUT), 0);
    check("rst_halt", 32'(dut.u_cpu.halt), 0);

    // JMP program
    clear_pgm();
    pgm[0] = 8'h65; pgm[1] = 8'h7A; pgm[10] = 8'hF0;
    start();
    edges(7);
    check("jmp_a1",  32'(dut.u_cpu.u_register_A.latched_data), 32'h05);
    check("jmp_pc1", 32'(dut.u_cpu.u_program_counter.counter_out), 32'h01);
    edges(7);
    check("jmp_pc2", 32'(dut.u_cpu.u_program_counter.counter_out), 32'h0A);
    check("jmp_a2",  32'(dut.u_cpu.u_register_A.latched_data), 32'h05);
    edges(7);
    check("jmp_halt", 32'(dut.u_cpu.halt), 1);
    edges(20);
    check("jmp_pc3",   32'(dut.u_cpu.u_program_counter.counter_out), 32'h0B);
    check("jmp_a3",    32'(dut.u_cpu.u_register_A.latched_data), 32'h05);
    check("jmp_halt2", 32'(dut.u_cpu.halt), 1);

    // Load / add / out
    clear_pgm();
    pgm[0] = 8'h1E; pgm[1] = 8'h2F; pgm[2] = 8'h30; pgm[3] = 8'hE0; pgm[4] = 8'hF0;
    pgm[14] = 8'h07; pgm[15] = 8'h03;
    start();
    run_compare("add", 5, 1'b1);
    check("add_out",  32'(register_OUT), 32'h0A);
    check("add_z",    32'(dut.u_cpu.flag_z), 0);
    check("add_halt", 32'(dut.u_cpu.halt), 1);
    dut.u_ram.dump();

    // SUB to zero then JZ taken / not taken
    for (int v = 0; v < 2; v++) begin
      clear_pgm();
      pgm[0] = 8'h65; pgm[1] = 8'h2F; pgm[2] = 8'h40; pgm[3] = 8'h98; pgm[8] = 8'hF0;
      pgm[15] = (v == 0) ? 8'h05 : 8'h03;
      start();
      run_compare("sub", 4, 1'b1);
      check("sub_pc", 32'(dut.u_cpu.u_program_counter.counter_out), (v == 0) ? 32'h08 : 32'h04);
      check("sub_z",  32'(dut.u_cpu.flag_z), (v == 0) ? 32'h1 : 32'h0);
    end

    // Overflow then JC
    clear_pgm();
    pgm[0] = 8'h1E; pgm[1] = 8'h2F; pgm[2] = 8'h30; pgm[3] = 8'h88; pgm[8] = 8'hF0;
    pgm[14] = 8'hFF; pgm[15] = 8'h01;
    start();
    run_compare("ovf", 3, 1'b1);
    check("ovf_a", 32'(dut.u_cpu.u_register_A.latched_data), 0);
    check("ovf_c", 32'(dut.u_cpu.flag_c), 1);
    check("ovf_z", 32'(dut.u_cpu.flag_z), 1);
    run_compare("ovf", 1, 1'b1);
    check("ovf_jc", 32'(dut.u_cpu.u_program_counter.counter_out), 32'h08);

    // STA/LDA round trip, then reset mid-instruction
    clear_pgm();
    pgm[0] = 8'h69; pgm[1] = 8'h5D; pgm[2] = 8'h60; pgm[3] = 8'h1D; pgm[4] = 8'hE0;
    start();
    run_compare("sta", 5, 1'b1);
    check("sta_a",   32'(dut.u_cpu.u_register_A.latched_data), 32'h09);
    check("sta_out", 32'(register_OUT), 32'h09);
    edges(3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_pc",  32'(dut.u_cpu.u_program_counter.counter_out), 0);
    check("mid_a",   32'(dut.u_cpu.u_register_A.latched_data), 0);
    check("mid_mem", 32'(dut.u_ram.mem[13]), 32'h09);

    // PC wrap through NOPs
    clear_pgm();
    pgm[0] = 8'h63;
    start();
    run_compare("wrap", 16, 1'b0);
    check("wrap_pc0", 32'(dut.u_cpu.u_program_counter.counter_out), 0);
    run_compare("wrap", 1, 1'b0);
    check("wrap_pc1", 32'(dut.u_cpu.u_program_counter.counter_out), 1);

    // Random programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) pgm[i] = 8'($urandom_range(0, 255));
      start();
      run_compare("rnd", 25, 1'b1);
      for (int i = 0; i < 16; i++) check("rnd_mem", 32'(dut.u_ram.mem[i]), m_mem[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
